// File: rtl/soc_ram_loader.sv
// soc_ram_loader: byte-stream boot loader that fills instruction/data RAM and releases the core on GO.
// Define LOADER_CHECKSUM_EN to append and verify an 8-bit additive checksum byte on every load frame.
module soc_ram_loader #(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  error
);

    localparam logic [7:0] CMD_IMEM = 8'h01;
    localparam logic [7:0] CMD_DMEM = 8'h02;
    localparam logic [7:0] CMD_GO   = 8'h03;

    // state  | meaning
    // IDLE   | waiting for a command byte
    // ADDR   | collecting 4 little-endian address bytes
    // LEN    | collecting 2 little-endian word-count bytes
    // DATA   | assembling words and issuing writes
    // CSUM   | waiting for the frame checksum byte (checksum build only)
    // RUN    | core released, input closed until reset
    // ERR    | sticky protocol error, input discarded until reset
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_RUN,
        S_ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FRAME_END = S_CSUM;
`else
    localparam state_t FRAME_END = S_IDLE;
`endif

    state_t                state;
    state_t                nxt;
    logic                  sel_dmem;
    logic [1:0]            byte_cnt;
    logic [23:0]           addr_sh;
    logic [7:0]            len_lo;
    logic [15:0]           words_left;
    logic [ADDR_WIDTH-3:0] word_addr;
    logic [23:0]           word_sh;
    logic                  take;
    logic [31:0]           addr_full;
    logic [15:0]           len_full;
    logic                  unused_addr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign take      = rx_valid && rx_ready;
    assign addr_full = {rx_data, addr_sh};
    assign len_full  = {rx_data, len_lo};
    // Byte offset and bits above the RAM size are ignored by design.
    assign unused_addr = ^{addr_full[31:ADDR_WIDTH], addr_full[1:0]};

    always_comb begin
        nxt = state;
        if (take) begin
            case (state)
                S_IDLE: begin
                    if (rx_data == CMD_IMEM || rx_data == CMD_DMEM)
                        nxt = S_ADDR;
                    else if (rx_data == CMD_GO)
                        nxt = S_RUN;
                    else
                        nxt = S_ERR;
                end
                S_ADDR: begin
                    if (byte_cnt == 2'd3)
                        nxt = S_LEN;
                end
                S_LEN: begin
                    if (byte_cnt[0])
                        nxt = (len_full == 16'd0) ? FRAME_END : S_DATA;
                end
                S_DATA: begin
                    if (byte_cnt == 2'd3 && words_left == 16'd1)
                        nxt = FRAME_END;
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    nxt = (rx_data == csum) ? S_IDLE : S_ERR;
                end
`endif
                default: nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rx_ready   <= 1'b1;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            error      <= 1'b0;
            imem_we    <= 1'b0;
            dmem_we    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            sel_dmem   <= 1'b0;
            byte_cnt   <= 2'd0;
            addr_sh    <= '0;
            len_lo     <= '0;
            words_left <= '0;
            word_addr  <= '0;
            word_sh    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state     <= nxt;
            rx_ready  <= (nxt != S_RUN);
            cpu_reset <= (nxt != S_RUN);
            error     <= (nxt == S_ERR);
            busy      <= !(nxt == S_IDLE || nxt == S_RUN || nxt == S_ERR);
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            if (take) begin
                case (state)
                    S_IDLE: begin
                        sel_dmem <= (rx_data == CMD_DMEM);
                        byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= rx_data;
`endif
                    end
                    S_ADDR: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        addr_sh  <= {rx_data, addr_sh[23:8]};
                        if (byte_cnt == 2'd3)
                            word_addr <= addr_full[ADDR_WIDTH-1:2];
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum + rx_data;
`endif
                    end
                    S_LEN: begin
                        len_lo <= rx_data;
                        if (byte_cnt[0]) begin
                            byte_cnt   <= 2'd0;
                            words_left <= len_full;
                        end else begin
                            byte_cnt <= 2'd1;
                        end
`ifdef LOADER_CHECKSUM_EN
                        csum   <= csum + rx_data;
`endif
                    end
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_sh  <= {rx_data, word_sh[23:8]};
                        // Output register is separate from word_sh, so the next word may start immediately.
                        if (byte_cnt == 2'd3) begin
                            mem_wdata  <= {rx_data, word_sh};
                            mem_addr   <= word_addr;
                            word_addr  <= word_addr + 1'b1;
                            words_left <= words_left - 16'd1;
                            imem_we    <= !sel_dmem;
                            dmem_we    <= sel_dmem;
                        end
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum + rx_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_soc_ram_loader.sv
// Directed self-checking bench for soc_ram_loader; also covers the LOADER_CHECKSUM_EN build.
module tb_soc_ram_loader;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic          dmem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          error;

    soc_ram_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          both_cnt = 0;
    logic [7:0]  csum_acc;
    logic        wr_dm[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (imem_we || dmem_we) begin
            wr_dm.push_back(dmem_we);
            wr_addr.push_back(32'(mem_addr));
            wr_data.push_back(mem_wdata);
        end
        if (imem_we && dmem_we) both_cnt++;
    end

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        csum_acc = csum_acc + b;
    endtask

    task idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task end_frame();
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum_acc);
`endif
        idle(3);
    endtask

    task clear_wr();
        wr_dm.delete();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        @(negedge clk);
        clear_wr();
    endtask

    task check_wr(input string tag, input int idx, input logic dm,
                  input logic [31:0] a, input logic [31:0] d);
        if (idx < wr_dm.size()) begin
            check({tag, ".sel"},  32'(wr_dm[idx]), 32'(dm));
            check({tag, ".addr"}, wr_addr[idx], a);
            check({tag, ".data"}, wr_data[idx], d);
        end else begin
            check({tag, ".present"}, 32'(wr_dm.size()), 32'(idx + 1));
        end
    endtask

    task send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        csum_acc = 8'h00;
        repeat (2) @(negedge clk);
        check("rst.rx_ready",  32'(rx_ready),  32'd1);
        check("rst.cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst.imem_we",   32'(imem_we),   32'd0);
        check("rst.dmem_we",   32'(dmem_we),   32'd0);
        check("rst.mem_addr",  32'(mem_addr),  32'd0);
        check("rst.mem_wdata", mem_wdata,      32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.error",     32'(error),     32'd0);
        reset = 1'b0;
        @(negedge clk);
        clear_wr();

        // instruction load, two back-to-back words
        csum_acc = 8'h00;
        send_byte(8'h01);
        send_byte(8'h00);
        check("iload.busy", 32'(busy), 32'd1);
        send_list('{8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
                    8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00});
        end_frame();
        check("iload.count", 32'(wr_dm.size()), 32'd2);
        check_wr("iload.w0", 0, 1'b0, 32'h0, 32'h0000_0013);
        check_wr("iload.w1", 1, 1'b0, 32'h1, 32'h0000_006F);
        check("iload.cpu_reset", 32'(cpu_reset), 32'd1);
        check("iload.busy_end",  32'(busy),      32'd0);
        clear_wr();

        // data load at byte offset 0x10, exact strobe timing
        csum_acc = 8'h00;
        send_list('{8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD});
        send_byte(8'hDE);
        @(negedge clk);
        rx_valid = 1'b0;
        check("dload.dmem_we",  32'(dmem_we),  32'd1);
        check("dload.imem_we",  32'(imem_we),  32'd0);
        check("dload.mem_addr", 32'(mem_addr), 32'd4);
        check("dload.wdata",    mem_wdata,     32'hDEAD_BEEF);
        @(negedge clk);
        check("dload.we_drop",  32'(dmem_we),  32'd0);
        check("dload.hold",     mem_wdata,     32'hDEAD_BEEF);
        end_frame();
        check("dload.count", 32'(wr_dm.size()), 32'd1);
        check("dload.error", 32'(error),        32'd0);
        clear_wr();

        // word address wrap, then a zero-length frame
        csum_acc = 8'h00;
        send_list('{8'h01, 8'hFC, 8'hFF, 8'h0F, 8'h00, 8'h02, 8'h00,
                    8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22});
        end_frame();
        check("wrap.count", 32'(wr_dm.size()), 32'd2);
        check_wr("wrap.w0", 0, 1'b0, 32'h3FFFF, 32'h1111_1111);
        check_wr("wrap.w1", 1, 1'b0, 32'h00000, 32'h2222_2222);
        csum_acc = 8'h00;
        send_list('{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        end_frame();
        check("len0.count", 32'(wr_dm.size()), 32'd2);
        check("len0.busy",  32'(busy),         32'd0);
        check("len0.error", 32'(error),        32'd0);

        // reset after two data bytes, then a fresh frame
        do_reset();
        csum_acc = 8'h00;
        send_list('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB});
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("midrst.busy",     32'(busy),     32'd0);
        check("midrst.rx_ready", 32'(rx_ready), 32'd1);
        reset = 1'b0;
        idle(3);
        check("midrst.no_wr", 32'(wr_dm.size()), 32'd0);
        csum_acc = 8'h00;
        send_list('{8'h02, 8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                    8'h44, 8'h33, 8'h22, 8'h11});
        end_frame();
        check("fresh.count", 32'(wr_dm.size()), 32'd1);
        check_wr("fresh.w0", 0, 1'b1, 32'h2, 32'h1122_3344);

        // bad command latches error and discards the rest
        do_reset();
        send_byte(8'h07);
        idle(1);
        check("bad.error",     32'(error),     32'd1);
        check("bad.cpu_reset", 32'(cpu_reset), 32'd1);
        check("bad.rx_ready",  32'(rx_ready),  32'd1);
        check("bad.busy",      32'(busy),      32'd0);
        send_list('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                    8'hAA, 8'hBB, 8'hCC, 8'hDD});
        idle(3);
        check("bad.no_wr",    32'(wr_dm.size()), 32'd0);
        check("bad.sticky",   32'(error),        32'd1);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        send_list('{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                    8'h01, 8'h02, 8'h03, 8'h04, 8'h0D});
        idle(3);
        check("csum_ok.error", 32'(error), 32'd0);
        check("csum_ok.busy",  32'(busy),  32'd0);
        check_wr("csum_ok.w0", 0, 1'b1, 32'h0, 32'h0403_0201);
        send_list('{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                    8'h01, 8'h02, 8'h03, 8'h04, 8'h0E});
        idle(3);
        check("csum_bad.error", 32'(error),        32'd1);
        check("csum_bad.count", 32'(wr_dm.size()), 32'd2);
        clear_wr();
`endif

        // load, then GO releases the core and closes the input
        do_reset();
        csum_acc = 8'h00;
        send_list('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                    8'h93, 8'h00, 8'h10, 8'h00});
        end_frame();
        check_wr("go.load", 0, 1'b0, 32'h0, 32'h0010_0093);
        clear_wr();
        send_byte(8'h03);
        check("go.before", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        check("go.cpu_reset", 32'(cpu_reset), 32'd0);
        check("go.rx_ready",  32'(rx_ready),  32'd0);
        send_list('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                    8'h11, 8'h22, 8'h33, 8'h44});
        idle(3);
        check("go.no_wr",     32'(wr_dm.size()), 32'd0);
        check("go.stay_run",  32'(cpu_reset),    32'd0);
        check("go.error",     32'(error),        32'd0);
        check("go.busy",      32'(busy),         32'd0);

        check("both_strobes", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
